// File: rtl/axicb_mst_cpl_track_if.sv
// Bus bundle for the slave-side completion tracker of one crossbar master port.
// The master modport is the crossbar/bench side that observes the address and
// completion handshakes. The slave modport is the tracker itself.
//   a_*      : observed address channel (valid/ready/id/len/originating master)
//   a_full   : slot addressed by a_id cannot take another request
//   c_*      : observed completion channel (valid/ready/last/id)
//   c_grant  : one-hot master the completion belongs to
//   c_len    : ALEN of the head request of the completion slot
//   c_orphan : completion accepted on an empty slot (pulse)
//   c_len_err: read burst beat count differed from ALEN+1 (pulse)
//   ostd_cnt : total outstanding requests
interface axicb_mst_cpl_track_if #(
    parameter int AXI_ID_W   = 8,
    parameter int MST_NB     = 4,
    parameter int ID_SLOT_NB = 4,
    parameter int SLOT_DEPTH = 4
);
    localparam int OSTD_W = $clog2(ID_SLOT_NB * SLOT_DEPTH + 1);

    logic                a_valid;
    logic                a_ready;
    logic                a_full;
    logic [AXI_ID_W-1:0] a_id;
    logic [7:0]          a_len;
    logic [MST_NB-1:0]   a_ix;
    logic                c_valid;
    logic                c_ready;
    logic                c_last;
    logic [AXI_ID_W-1:0] c_id;
    logic [MST_NB-1:0]   c_grant;
    logic [7:0]          c_len;
    logic                c_orphan;
    logic                c_len_err;
    logic [OSTD_W-1:0]   ostd_cnt;

    modport master (
        output a_valid, a_ready, a_id, a_len, a_ix,
        output c_valid, c_ready, c_last, c_id,
        input  a_full, c_grant, c_len, c_orphan, c_len_err, ostd_cnt
    );

    modport slave (
        input  a_valid, a_ready, a_id, a_len, a_ix,
        input  c_valid, c_ready, c_last, c_id,
        output a_full, c_grant, c_len, c_orphan, c_len_err, ostd_cnt
    );
endinterface

// File: rtl/axicb_mst_cpl_track.sv
// Slave-side completion tracker for one crossbar master port.
// Every accepted address request is queued in a per-ID-slot circular buffer
// holding {originating master one-hot, ALEN}. Completions look up the head
// entry of their slot to route back to the issuing master. Completions on an
// empty slot are flagged as orphans; on the read path, bursts whose beat count
// disagrees with ALEN+1 are flagged as length errors.
// Ports:
//   aclk   : clock
//   areset : asynchronous active-high reset
//   srst   : synchronous active-high reset, same effect as areset
//   bus    : tracker side of axicb_mst_cpl_track_if (see interface header)
module axicb_mst_cpl_track #(
    parameter int RD_PATH    = 0,
    parameter int AXI_ID_W   = 8,
    parameter int MST_NB     = 4,
    parameter int ID_SLOT_NB = 4,
    parameter int SLOT_DEPTH = 4
) (
    input  logic aclk,
    input  logic areset,
    input  logic srst,
    axicb_mst_cpl_track_if.slave bus
);
    localparam int   SLOT_W = $clog2(ID_SLOT_NB);
    localparam int   PTR_W  = $clog2(SLOT_DEPTH);
    localparam int   CNT_W  = $clog2(SLOT_DEPTH + 1);
    localparam int   OSTD_W = $clog2(ID_SLOT_NB * SLOT_DEPTH + 1);
    localparam int   ENT_W  = MST_NB + 8;
    localparam logic IS_RD  = (RD_PATH != 0);

    logic [ENT_W-1:0]  mem_r    [ID_SLOT_NB][SLOT_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r [ID_SLOT_NB];
    logic [PTR_W-1:0]  wr_ptr_r [ID_SLOT_NB];
    logic [CNT_W-1:0]  cnt_r    [ID_SLOT_NB];
    logic [8:0]        beat_r   [ID_SLOT_NB];
    logic [OSTD_W-1:0] ostd_r;
    logic              orphan_r;
    logic              len_err_r;

    logic [SLOT_W-1:0]     a_slot_s;
    logic [SLOT_W-1:0]     c_slot_s;
    logic                  a_full_s;
    logic                  c_empty_s;
    logic [ENT_W-1:0]      head_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  hit_s;
    logic                  beat_inc_s;
    logic                  orphan_s;
    logic                  len_err_s;
    logic [MST_NB-1:0]     grant_s;
    logic [7:0]            len_s;
    logic [OSTD_W-1:0]     ostd_nxt_s;
    logic [ID_SLOT_NB-1:0] push_vec_s;
    logic [ID_SLOT_NB-1:0] pop_vec_s;
    logic [ID_SLOT_NB-1:0] inc_vec_s;
    logic                  unused_s;

    // Only the low ID bits select a slot.
    assign unused_s = ^{bus.a_id[AXI_ID_W-1:SLOT_W], bus.c_id[AXI_ID_W-1:SLOT_W]};

    // Slot decode, head lookup and push/pop/error qualification.
    always_comb begin
        a_slot_s   = bus.a_id[SLOT_W-1:0];
        c_slot_s   = bus.c_id[SLOT_W-1:0];
        a_full_s   = (cnt_r[a_slot_s] == CNT_W'(SLOT_DEPTH));
        c_empty_s  = (cnt_r[c_slot_s] == {CNT_W{1'b0}});
        head_s     = mem_r[c_slot_s][rd_ptr_r[c_slot_s]];
        push_s     = bus.a_valid & bus.a_ready & ~a_full_s;
        hit_s      = bus.c_valid & bus.c_ready & ~c_empty_s;
        orphan_s   = bus.c_valid & bus.c_ready & c_empty_s;
        // Every B response ends its transaction; R only on RLAST.
        pop_s      = hit_s & (~IS_RD | bus.c_last);
        beat_inc_s = hit_s & IS_RD & ~bus.c_last;
        // Beats before the last one must equal ALEN (counter+1 vs ALEN+1).
        len_err_s  = hit_s & IS_RD & bus.c_last & (beat_r[c_slot_s] != {1'b0, head_s[7:0]});
        if (c_empty_s) begin
            grant_s = {MST_NB{1'b0}};
            len_s   = 8'd0;
        end else begin
            grant_s = head_s[ENT_W-1:8];
            len_s   = IS_RD ? head_s[7:0] : 8'd0;
        end
        if (push_s && !pop_s) begin
            ostd_nxt_s = ostd_r + OSTD_W'(1);
        end else if (pop_s && !push_s) begin
            ostd_nxt_s = ostd_r - OSTD_W'(1);
        end else begin
            ostd_nxt_s = ostd_r;
        end
    end

    // Per-slot one-hot strobes for the slot state update.
    always_comb begin
        push_vec_s = {ID_SLOT_NB{1'b0}};
        pop_vec_s  = {ID_SLOT_NB{1'b0}};
        inc_vec_s  = {ID_SLOT_NB{1'b0}};
        for (int s = 0; s < ID_SLOT_NB; s++) begin
            push_vec_s[s] = push_s & (a_slot_s == SLOT_W'(s));
            pop_vec_s[s]  = pop_s & (c_slot_s == SLOT_W'(s));
            inc_vec_s[s]  = beat_inc_s & (c_slot_s == SLOT_W'(s));
        end
    end

    // Entry storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge aclk) begin
        if (push_s) begin
            mem_r[a_slot_s][wr_ptr_r[a_slot_s]] <= {bus.a_ix, bus.a_len};
        end
    end

    // Slot pointers, counts, beat counters, outstanding total and error pulses.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int s = 0; s < ID_SLOT_NB; s++) begin
                rd_ptr_r[s] <= {PTR_W{1'b0}};
                wr_ptr_r[s] <= {PTR_W{1'b0}};
                cnt_r[s]    <= {CNT_W{1'b0}};
                beat_r[s]   <= 9'd0;
            end
            ostd_r    <= {OSTD_W{1'b0}};
            orphan_r  <= 1'b0;
            len_err_r <= 1'b0;
        end else if (srst) begin
            for (int s = 0; s < ID_SLOT_NB; s++) begin
                rd_ptr_r[s] <= {PTR_W{1'b0}};
                wr_ptr_r[s] <= {PTR_W{1'b0}};
                cnt_r[s]    <= {CNT_W{1'b0}};
                beat_r[s]   <= 9'd0;
            end
            ostd_r    <= {OSTD_W{1'b0}};
            orphan_r  <= 1'b0;
            len_err_r <= 1'b0;
        end else begin
            for (int s = 0; s < ID_SLOT_NB; s++) begin
                if (push_vec_s[s]) begin
                    wr_ptr_r[s] <= wr_ptr_r[s] + PTR_W'(1);
                end
                if (pop_vec_s[s]) begin
                    rd_ptr_r[s] <= rd_ptr_r[s] + PTR_W'(1);
                end
                case ({push_vec_s[s], pop_vec_s[s]})
                    2'b10:   cnt_r[s] <= cnt_r[s] + CNT_W'(1);
                    2'b01:   cnt_r[s] <= cnt_r[s] - CNT_W'(1);
                    default: cnt_r[s] <= cnt_r[s];
                endcase
                // Saturate at 256 so an overlong burst still reports an error.
                if (pop_vec_s[s]) begin
                    beat_r[s] <= 9'd0;
                end else if (inc_vec_s[s] && (beat_r[s] != 9'd256)) begin
                    beat_r[s] <= beat_r[s] + 9'd1;
                end
            end
            ostd_r    <= ostd_nxt_s;
            orphan_r  <= orphan_s;
            len_err_r <= len_err_s;
        end
    end

    assign bus.a_full    = a_full_s;
    assign bus.c_grant   = grant_s;
    assign bus.c_len     = len_s;
    assign bus.c_orphan  = orphan_r;
    assign bus.c_len_err = len_err_r;
    assign bus.ostd_cnt  = ostd_r;
endmodule

// File: tb/tb_axicb_mst_cpl_track.sv
// Drives a write-path (index 0) and a read-path (index 1) tracker with the
// same stimulus and checks both against a queue-based model every cycle.
module tb_axicb_mst_cpl_track;
    logic       aclk = 1'b0;
    logic       areset;
    logic       srst;
    logic       a_valid, a_ready, c_valid, c_ready, c_last;
    logic [7:0] a_id, a_len, c_id;
    logic [3:0] a_ix;
    logic       chk_en = 1'b0;
    int         n_chk  = 0;
    int         n_pass = 0;

    always #5 aclk = ~aclk;

    axicb_mst_cpl_track_if bus_w ();
    axicb_mst_cpl_track_if bus_r ();

    assign bus_w.a_valid = a_valid;  assign bus_r.a_valid = a_valid;
    assign bus_w.a_ready = a_ready;  assign bus_r.a_ready = a_ready;
    assign bus_w.a_id    = a_id;     assign bus_r.a_id    = a_id;
    assign bus_w.a_len   = a_len;    assign bus_r.a_len   = a_len;
    assign bus_w.a_ix    = a_ix;     assign bus_r.a_ix    = a_ix;
    assign bus_w.c_valid = c_valid;  assign bus_r.c_valid = c_valid;
    assign bus_w.c_ready = c_ready;  assign bus_r.c_ready = c_ready;
    assign bus_w.c_last  = c_last;   assign bus_r.c_last  = c_last;
    assign bus_w.c_id    = c_id;     assign bus_r.c_id    = c_id;

    axicb_mst_cpl_track #(.RD_PATH(0)) dut_w (.aclk(aclk), .areset(areset), .srst(srst), .bus(bus_w.slave));
    axicb_mst_cpl_track #(.RD_PATH(1)) dut_r (.aclk(aclk), .areset(areset), .srst(srst), .bus(bus_r.slave));

    // Model: per path, per slot queue of {ix, len}; per-slot beats seen so far.
    logic [11:0] mq [2][4][$];
    int          mb [2][4];
    logic        exp_orph [2];
    logic        exp_lerr [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    always @(posedge aclk or posedge areset) begin : model
        int  as, cs;
        bit  push, hs, empty;
        if (areset || srst) begin
            for (int k = 0; k < 2; k++) begin
                for (int s = 0; s < 4; s++) begin
                    mq[k][s].delete();
                    mb[k][s] = 0;
                end
                exp_orph[k] = 1'b0;
                exp_lerr[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                as    = int'(a_id[1:0]);
                cs    = int'(c_id[1:0]);
                push  = a_valid && a_ready && (mq[k][as].size() < 4);
                hs    = c_valid && c_ready;
                empty = (mq[k][cs].size() == 0);
                exp_orph[k] = hs && empty;
                exp_lerr[k] = 1'b0;
                if (hs && !empty) begin
                    if (k == 0 || c_last) begin
                        if (k == 1) exp_lerr[k] = (mb[k][cs] != int'(mq[k][cs][0][7:0]));
                        void'(mq[k][cs].pop_front());
                        mb[k][cs] = 0;
                    end else if (mb[k][cs] < 256) begin
                        mb[k][cs] = mb[k][cs] + 1;
                    end
                end
                if (push) mq[k][as].push_back({a_ix, a_len});
            end
        end
    end

    task automatic cmp(input int k, input logic full, input logic [3:0] gr, input logic [7:0] ln,
                       input logic orph, input logic lerr, input logic [4:0] ostd);
        int as, cs, tot;
        logic [3:0] eg;
        logic [7:0] el;
        as  = int'(a_id[1:0]);
        cs  = int'(c_id[1:0]);
        tot = 0;
        for (int s = 0; s < 4; s++) tot += mq[k][s].size();
        eg = (mq[k][cs].size() == 0) ? 4'd0 : mq[k][cs][0][11:8];
        el = (k == 1 && mq[k][cs].size() != 0) ? mq[k][cs][0][7:0] : 8'd0;
        chk($sformatf("a_full[%0d]", k), 32'(full), 32'(mq[k][as].size() == 4));
        chk($sformatf("c_grant[%0d]", k), 32'(gr), 32'(eg));
        chk($sformatf("c_len[%0d]", k), 32'(ln), 32'(el));
        chk($sformatf("c_orphan[%0d]", k), 32'(orph), 32'(exp_orph[k]));
        chk($sformatf("c_len_err[%0d]", k), 32'(lerr), 32'(exp_lerr[k]));
        chk($sformatf("ostd_cnt[%0d]", k), 32'(ostd), 32'(tot));
    endtask

    always @(negedge aclk) begin : compare
        if (chk_en) begin
            cmp(0, bus_w.a_full, bus_w.c_grant, bus_w.c_len, bus_w.c_orphan, bus_w.c_len_err, bus_w.ostd_cnt);
            cmp(1, bus_r.a_full, bus_r.c_grant, bus_r.c_len, bus_r.c_orphan, bus_r.c_len_err, bus_r.ostd_cnt);
        end
    end

    task automatic idle();
        a_valid = 1'b0; a_ready = 1'b0; a_id = 8'd0; a_len = 8'd0; a_ix = 4'd0;
        c_valid = 1'b0; c_ready = 1'b0; c_last = 1'b0; c_id = 8'd0;
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input logic [7:0] id, input logic [7:0] len, input logic [3:0] ix);
        idle();
        a_valid = 1'b1; a_ready = 1'b1; a_id = id; a_len = len; a_ix = ix;
        cyc();
    endtask

    task automatic cpl_set(input logic [7:0] id, input logic last);
        idle();
        c_valid = 1'b1; c_ready = 1'b1; c_id = id; c_last = last;
    endtask

    initial begin
        idle();
        srst   = 1'b0;
        areset = 1'b1;
        repeat (2) cyc();
        areset = 1'b0;
        chk_en = 1'b1;
        @(negedge aclk);
        chk("rst_ostd", 32'(bus_r.ostd_cnt), 32'd0);
        chk("rst_grant", 32'(bus_r.c_grant), 32'd0);

        // Single read burst: id 1, len 3, master 2.
        push(8'h01, 8'd3, 4'b0100);
        for (int b = 0; b < 4; b++) begin
            cpl_set(8'h01, b == 3);
            @(negedge aclk);
            chk("burst_grant", 32'(bus_r.c_grant), 32'h4);
            chk("burst_len", 32'(bus_r.c_len), 32'd3);
            if (b == 0) chk("burst_ostd1", 32'(bus_r.ostd_cnt), 32'd1);
            cyc();
        end
        idle();
        @(negedge aclk);
        chk("burst_ostd0", 32'(bus_r.ostd_cnt), 32'd0);
        chk("burst_noerr", 32'(bus_r.c_len_err), 32'd0);
        cyc();

        // Fill slot 2, then attempt a push while popping.
        for (int i = 0; i < 4; i++) push(8'h02, 8'd0, 4'(1 << i));
        idle();
        a_id = 8'h02;
        @(negedge aclk);
        chk("full_slot2", 32'(bus_r.a_full), 32'd1);
        a_id = 8'h03;
        #1;
        chk("notfull_slot3", 32'(bus_r.a_full), 32'd0);
        cyc();
        cpl_set(8'h02, 1'b1);
        a_valid = 1'b1; a_ready = 1'b1; a_id = 8'h02; a_ix = 4'b1000;
        cyc();
        idle();
        a_id = 8'h02;
        @(negedge aclk);
        chk("full_after_pop", 32'(bus_r.a_full), 32'd0);
        chk("ostd_after_pop", 32'(bus_r.ostd_cnt), 32'd3);
        cyc();
        for (int i = 0; i < 3; i++) begin
            cpl_set(8'h02, 1'b1);
            cyc();
        end

        // Short burst: len 1 but last on first beat.
        push(8'h00, 8'd1, 4'b0001);
        cpl_set(8'h00, 1'b1);
        cyc();
        idle();
        @(negedge aclk);
        chk("len_err_hi", 32'(bus_r.c_len_err), 32'd1);
        cyc();
        @(negedge aclk);
        chk("len_err_lo", 32'(bus_r.c_len_err), 32'd0);

        // Orphan on empty slot 3.
        cpl_set(8'h03, 1'b1);
        @(negedge aclk);
        chk("orphan_grant", 32'(bus_r.c_grant), 32'd0);
        cyc();
        idle();
        @(negedge aclk);
        chk("orphan_pulse", 32'(bus_r.c_orphan), 32'd1);
        cyc();

        // Interleaved bursts on id 0 (len 2) and id 1 (len 1).
        push(8'h00, 8'd2, 4'b0001);
        push(8'h01, 8'd1, 4'b0010);
        cpl_set(8'h00, 1'b0);
        @(negedge aclk);
        chk("ilv_grant0", 32'(bus_r.c_grant), 32'h1);
        cyc();
        cpl_set(8'h01, 1'b0);
        @(negedge aclk);
        chk("ilv_grant1", 32'(bus_r.c_grant), 32'h2);
        cyc();
        cpl_set(8'h00, 1'b0); cyc();
        cpl_set(8'h01, 1'b1); cyc();
        cpl_set(8'h00, 1'b1); cyc();
        idle();
        @(negedge aclk);
        chk("ilv_ostd", 32'(bus_r.ostd_cnt), 32'd0);
        cyc();

        // Write path: three pushes, one B, then async reset mid-cycle.
        push(8'h00, 8'd0, 4'b0001);
        push(8'h00, 8'd0, 4'b0010);
        push(8'h00, 8'd0, 4'b0100);
        cpl_set(8'h00, 1'b1);
        cyc();
        idle();
        @(negedge aclk);
        chk("wr_ostd2", 32'(bus_w.ostd_cnt), 32'd2);
        chk("wr_head", 32'(bus_w.c_grant), 32'h2);
        cyc();
        #2 areset = 1'b1;
        @(negedge aclk);
        chk("arst_ostd", 32'(bus_w.ostd_cnt), 32'd0);
        chk("arst_grant", 32'(bus_w.c_grant), 32'd0);
        cyc();
        areset = 1'b0;
        cpl_set(8'h00, 1'b1);
        cyc();
        idle();
        @(negedge aclk);
        chk("post_rst_orphan", 32'(bus_w.c_orphan), 32'd1);
        cyc();

        // Synchronous reset clears tracking.
        push(8'h01, 8'd0, 4'b0001);
        srst = 1'b1;
        cyc();
        srst = 1'b0;
        @(negedge aclk);
        chk("srst_ostd", 32'(bus_r.ostd_cnt), 32'd0);
        cyc();
        cyc();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
